// File: rtl/radio_multi.sv
// Multi-channel RC PWM decoder: synchronised inputs, shared tick prescaler,
// plausibility-checked width measurement. Optional failsafe: RADIO_FAILSAFE_EN.
module radio_multi #(
  parameter int NCH       = 6,
  parameter int OUT_W     = 10,
  parameter int CTR_W     = 12,
  parameter int TICK_DIV  = 50,
  parameter int OFFSET    = 987,
  parameter int PULSE_MIN = 800,
  parameter int PULSE_MAX = 2200,
  parameter int DEFAULT   = 512,
  parameter int TIMEOUT   = 25000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     sig,
  output logic [NCH*OUT_W-1:0] val,
  output logic [NCH-1:0]     upd,
  output logic [NCH-1:0]     lost
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [OUT_W-1:0] VAL_DEF  = OUT_W'(DEFAULT);

  logic [PW-1:0]    pre;
  logic             tick;
  logic [1:0]       settle;
  logic             live;
  logic [NCH-1:0]   s1, s2, p;
  logic [NCH-1:0]   fall_q;
  logic [NCH-1:0]   armed;
  logic [CTR_W-1:0] cnt   [NCH];
  logic [OUT_W-1:0] val_r [NCH];

`ifdef RADIO_FAILSAFE_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0]  idle [NCH];
  logic [NCH-1:0] lost_r;

  assign lost = lost_r;
`else
  assign lost = '0;
`endif

  // s1/s2/p only carry real input data three edges after reset; an edge seen
  // before then is an artefact of the cleared synchronisers, not a rise.
  assign live = (settle == 2'd3);

  function automatic logic accept(input logic [CTR_W-1:0] w);
    return (int'(w) >= PULSE_MIN) && (int'(w) <= PULSE_MAX);
  endfunction

  function automatic logic [OUT_W-1:0] map_width(input logic [CTR_W-1:0] w);
    int d;
    d = int'(w) - OFFSET;
    if (d < 0)
      return '0;
    else if (d > (2 ** OUT_W) - 1)
      return '1;
    else
      return OUT_W'(d);
  endfunction

  always_comb begin
    val = '0;
    for (int unsigned i = 0; i < NCH; i++)
      val[i*OUT_W +: OUT_W] = val_r[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre    <= '0;
      tick   <= 1'b0;
      settle <= '0;
      s1     <= '0;
      s2     <= '0;
      p      <= '0;
      fall_q <= '0;
      armed  <= '0;
      upd    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        val_r[i] <= VAL_DEF;
`ifdef RADIO_FAILSAFE_EN
        idle[i]  <= '0;
`endif
      end
`ifdef RADIO_FAILSAFE_EN
      lost_r <= '1;
`endif
    end else begin
      tick <= (pre == PRE_LAST);
      pre  <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      if (!live)
        settle <= settle + 2'd1;
      s1  <= sig;
      s2  <= s1;
      p   <= s2;
      upd <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        // Width follows the delayed level p so the fall edge's tick is counted.
        if (live && s2[i] && !p[i]) begin
          armed[i] <= 1'b1;
          cnt[i]   <= '0;
        end else if (tick && p[i] && cnt[i] != CTR_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        fall_q[i] <= armed[i] && p[i] && !s2[i];
        if (fall_q[i] && accept(cnt[i])) begin
          val_r[i] <= map_width(cnt[i]);
          upd[i]   <= 1'b1;
        end
`ifdef RADIO_FAILSAFE_EN
        if (fall_q[i] && accept(cnt[i])) begin
          idle[i]   <= '0;
          lost_r[i] <= 1'b0;
        end else if (tick && idle[i] != IDLE_MAX) begin
          idle[i] <= idle[i] + 1'b1;
          if (idle[i] == IDLE_LAST) begin
            val_r[i]  <= VAL_DEF;
            lost_r[i] <= 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_radio_multi.sv
// Randomised bench for radio_multi against a pulse-level reference model.
module tb_radio_multi;

  localparam int NCH   = 6;
  localparam int OUT_W = 10;
  localparam int DEF   = 512;
  localparam int OFS   = 987;
  localparam int PMIN  = 800;
  localparam int PMAX  = 2200;
`ifdef RADIO_FAILSAFE_EN
  localparam int TO = 100;
  localparam bit FS = 1'b1;
`else
  localparam int TO = 25000;
  localparam bit FS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       sig;
  logic [NCH*OUT_W-1:0] val;
  logic [NCH-1:0]       upd;
  logic [NCH-1:0]       lost;

  always #5 clk = ~clk;

  radio_multi #(
    .NCH(NCH), .OUT_W(OUT_W), .TICK_DIV(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .val(val), .upd(upd), .lost(lost)
  );

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  seg_t plan [NCH][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lvl [NCH];
  int   remain [NCH];
  bit   armed [NCH];
  int   rise_c [NCH];
  int   due [NCH];
  int   dval [NCH];
  int   last_acc [NCH];
  int   mval [NCH];
  bit   mlost [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int map_w(input int w);
    if (w < OFS) return 0;
    if (w - OFS > 1023) return 1023;
    return w - OFS;
  endfunction

  function automatic logic [NCH*OUT_W-1:0] exp_val();
    logic [NCH*OUT_W-1:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) v[ch*OUT_W +: OUT_W] = OUT_W'(mval[ch]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_lost();
    logic [NCH-1:0] l;
    for (int ch = 0; ch < NCH; ch++) l[ch] = mlost[ch];
    return l;
  endfunction

  function automatic bit busy();
    for (int ch = 0; ch < NCH; ch++)
      if (plan[ch].size() > 0 || remain[ch] > 0 || due[ch] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add(input int ch, input bit l, input int len);
    seg_t s;
    s.lvl = l;
    s.len = len;
    plan[ch].push_back(s);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      armed[ch]    = 1'b0;
      due[ch]      = -1;
      last_acc[ch] = -1;
      mval[ch]     = DEF;
      mlost[ch]    = FS;
      remain[ch]   = 0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    model_reset();
    check("rst_val", val, exp_val());
    check("rst_upd", upd, '0);
    check("rst_lost", lost, exp_lost());
    rst = 1'b1;
  endtask

  task automatic step();
    logic [NCH-1:0] eupd;
    bit nl;
    seg_t s;
    @(posedge clk);
    cyc++;
    #1;
    eupd = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (due[ch] == cyc) begin
        mval[ch]     = dval[ch];
        mlost[ch]    = 1'b0;
        eupd[ch]     = 1'b1;
        last_acc[ch] = cyc;
        due[ch]      = -1;
      end else if (FS && last_acc[ch] >= 0 && cyc == last_acc[ch] + TO) begin
        mval[ch]  = DEF;
        mlost[ch] = 1'b1;
      end
    end
    check("upd", upd, eupd);
    check("val", val, exp_val());
    check("lost", lost, exp_lost());
    for (int ch = 0; ch < NCH; ch++) begin
      nl = lvl[ch];
      if (remain[ch] == 0 && plan[ch].size() > 0) begin
        s = plan[ch].pop_front();
        nl = s.lvl;
        remain[ch] = s.len;
      end
      if (remain[ch] > 0) remain[ch]--;
      if (nl && !lvl[ch]) begin
        armed[ch]  = 1'b1;
        rise_c[ch] = cyc;
      end else if (!nl && lvl[ch] && armed[ch]) begin
        if (cyc - rise_c[ch] >= PMIN && cyc - rise_c[ch] <= PMAX) begin
          due[ch]  = cyc + 4;
          dval[ch] = map_w(cyc - rise_c[ch]);
        end
      end
      lvl[ch] = nl;
      sig[ch] = nl;
    end
  endtask

  task automatic run(input int tail);
    int start;
    start = cyc;
    while (busy()) begin
      if (cyc - start > 60000) begin
        check("run_budget", 1, 0);
        break;
      end
      step();
    end
    repeat (tail) step();
  endtask

  int special [10] = '{799, 800, 2200, 2201, 986, 987, 988, 2010, 2011, 1500};

  initial begin
    rst = 1'b0;
    sig = '0;
    sig[1] = 1'b1;
    for (int ch = 0; ch < NCH; ch++) lvl[ch] = sig[ch];
    do_reset(4);

    // Directed: mapping points, plausibility limits, high-at-reset, simultaneous pulses
    add(0, 0, 20);
    foreach (special[k]) begin end
    add(0, 1, 1500); add(0, 0, 60);
    add(0, 1, 900);  add(0, 0, 60);
    add(0, 1, 987);  add(0, 0, 60);
    add(0, 1, 2010); add(0, 0, 60);
    add(0, 1, 2100); add(0, 0, 60);
    add(0, 1, 1500); add(0, 0, 60);
    add(0, 1, 799);  add(0, 0, 60);
    add(0, 1, 2201); add(0, 0, 150);
    add(1, 1, 300);  add(1, 0, 200); add(1, 1, 1200); add(1, 0, 20);
    add(2, 0, 30);   add(2, 1, 1100); add(2, 0, 20);
    add(3, 0, 30);   add(3, 1, 1700); add(3, 0, 20);
    add(4, 0, 30);   add(4, 1, 1900); add(4, 0, 20);
    run(150);

    // Randomised pulses with boundary widths mixed in
    for (int ch = 0; ch < NCH; ch++) begin
      repeat (6) begin
        add(ch, 0, $urandom_range(5, 250));
        if ($urandom_range(0, 2) == 0)
          add(ch, 1, special[$urandom_range(0, 9)]);
        else
          add(ch, 1, $urandom_range(780, 2220));
      end
      add(ch, 0, 150);
    end
    run(150);

    // Reset in the middle of a pulse on ch0
    add(0, 0, 10);
    add(0, 1, 500);
    run(0);
    do_reset(3);
    add(0, 1, 400); add(0, 0, 200); add(0, 1, 1500); add(0, 0, 20);
    run(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
